inhibit_gate_bank: RTL and testbench



---
 rtl/inhibit_gate_pkg.sv | 15 +
 rtl/inhibit_gate_ch.sv | 93 +++++++++
 rtl/inhibit_gate_bank.sv | 41 ++++
 tb/tb_inhibit_gate_bank.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/inhibit_gate_pkg.sv
// Shared types and helpers for the inhibit gate bank.
package inhibit_gate_pkg;

  typedef enum logic [1:0] {
    StPass    = 2'd0,
    StInhibit = 2'd1,
    StBlank   = 2'd2
  } gate_state_t;

  // Width of the blanking counter; never narrower than one bit.
  function automatic int unsigned bcnt_width(input int unsigned hold);
    return (hold == 0) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/inhibit_gate_ch.sv
// One channel of the inhibit gate bank: blanking FSM, registered output, rise flag.
// Event counter present only when INHIBIT_GATE_EVCNT_EN is defined.
module inhibit_gate_ch
  import inhibit_gate_pkg::*;
#(
  parameter int unsigned HOLD  = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             in1,
  input  logic             in2,
  output logic             out,
  output logic             rise,
  output logic [CNT_W-1:0] cnt,
  output gate_state_t      state
);

  localparam int unsigned BW = bcnt_width(HOLD);
  localparam logic [BW-1:0] HoldVal = BW'(HOLD);

  gate_state_t   state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          out_q, rise_q;
  logic          out_nxt, gated, rise_d;

  always_comb begin
    state_d = StPass;
    bcnt_d  = '0;
    out_nxt = 1'b0;
    if (in2) begin
      state_d = StInhibit;
      bcnt_d  = HoldVal;
    end else if (bcnt_q != '0) begin
      state_d = StBlank;
      bcnt_d  = bcnt_q - 1'b1;
    end else begin
      out_nxt = in1;
    end
  end

  assign gated  = out_nxt & en;
  assign rise_d = gated & ~out_q;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= StPass;
      bcnt_q  <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      out_q   <= gated;
      rise_q  <= rise_d;
    end
  end

`ifdef INHIBIT_GATE_EVCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear beats increment; counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (rise_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign cnt        = '0;
`endif

  assign out   = out_q;
  assign rise  = rise_q;
  assign state = state_q;

endmodule

// File: rtl/inhibit_gate_bank.sv
// CH independent registered inhibit gates with post-inhibit blanking.
// Define INHIBIT_GATE_EVCNT_EN to build the per-channel event counters.
module inhibit_gate_bank
  import inhibit_gate_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned HOLD  = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                areset_n,
  input  logic                en,
  input  logic                clr,
  input  logic [CH-1:0]       in1,
  input  logic [CH-1:0]       in2,
  output logic [CH-1:0]       out,
  output logic [CH-1:0]       rise,
  output logic [CH*CNT_W-1:0] cnt
);

  gate_state_t unused_state [CH];

  for (genvar g = 0; g < CH; g++) begin : g_ch
    inhibit_gate_ch #(
      .HOLD  (HOLD),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk),
      .areset_n (areset_n),
      .en       (en),
      .clr      (clr),
      .in1      (in1[g]),
      .in2      (in2[g]),
      .out      (out[g]),
      .rise     (rise[g]),
      .cnt      (cnt[g*CNT_W +: CNT_W]),
      .state    (unused_state[g])
    );
  end

endmodule

// File: tb/tb_inhibit_gate_bank.sv
// Scoreboard bench: two bank instances (HOLD=3/CNT_W=2 and HOLD=0/CNT_W=8) on shared stimulus.
module tb_inhibit_gate_bank;

`ifdef INHIBIT_GATE_EVCNT_EN
  localparam bit EvCnt = 1'b1;
`else
  localparam bit EvCnt = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  in1 = '0;
  logic [3:0]  in2 = '0;
  logic [3:0]  out_a, rise_a, out_b, rise_b;
  logic [7:0]  cnt_a;
  logic [31:0] cnt_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  out_a;
    logic [3:0]  rise_a;
    logic [7:0]  cnt_a;
    logic [3:0]  out_b;
    logic [3:0]  rise_b;
    logic [31:0] cnt_b;
  } exp_t;

  exp_t sb[$];

  int   m_bcnt [2][4];
  logic m_out  [2][4];
  logic m_rise [2][4];
  int   m_cnt  [2][4];

  always #5 clk = ~clk;

  inhibit_gate_bank #(.CH(4), .HOLD(3), .CNT_W(2)) u_dut_a (
    .clk(clk), .areset_n(areset_n), .en(en), .clr(clr), .in1(in1), .in2(in2),
    .out(out_a), .rise(rise_a), .cnt(cnt_a)
  );

  inhibit_gate_bank #(.CH(4), .HOLD(0), .CNT_W(8)) u_dut_b (
    .clk(clk), .areset_n(areset_n), .en(en), .clr(clr), .in1(in1), .in2(in2),
    .out(out_b), .rise(rise_b), .cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        m_bcnt[d][i] = 0;
        m_out[d][i]  = 1'b0;
        m_rise[d][i] = 1'b0;
        m_cnt[d][i]  = 0;
      end
  endtask

  // Predict the next edge from current inputs, push, clock, pop and compare.
  task automatic step();
    exp_t e;
    logic on;
    int   hv, mx;
    for (int d = 0; d < 2; d++) begin
      hv = (d == 0) ? 3 : 0;
      mx = (d == 0) ? 3 : 255;
      for (int i = 0; i < 4; i++) begin
        on = 1'b0;
        if (in2[i]) m_bcnt[d][i] = hv;
        else if (m_bcnt[d][i] != 0) m_bcnt[d][i] = m_bcnt[d][i] - 1;
        else on = in1[i];
        m_rise[d][i] = on & en & ~m_out[d][i];
        m_out[d][i]  = on & en;
        if (clr) m_cnt[d][i] = 0;
        else if (m_rise[d][i] && m_cnt[d][i] < mx) m_cnt[d][i] = m_cnt[d][i] + 1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      e.out_a[i]          = m_out[0][i];
      e.rise_a[i]         = m_rise[0][i];
      e.cnt_a[i*2 +: 2]   = EvCnt ? 2'(m_cnt[0][i]) : 2'd0;
      e.out_b[i]          = m_out[1][i];
      e.rise_b[i]         = m_rise[1][i];
      e.cnt_b[i*8 +: 8]   = EvCnt ? 8'(m_cnt[1][i]) : 8'd0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("out_a", 32'(out_a), 32'(e.out_a));
      check("rise_a", 32'(rise_a), 32'(e.rise_a));
      check("cnt_a", 32'(cnt_a), 32'(e.cnt_a));
      check("out_b", 32'(out_b), 32'(e.out_b));
      check("rise_b", 32'(rise_b), 32'(e.rise_b));
      check("cnt_b", cnt_b, e.cnt_b);
    end
  endtask

  initial begin
    logic [3:0] pin1, pin2;
    logic [1:0] sat_exp [5];
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    // Reset held with requests asserted
    model_reset();
    areset_n = 1'b0; in1 = 4'hF; in2 = 4'h0; en = 1'b1; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_a", 32'(out_a), 32'd0);
    check("rst_rise_a", 32'(rise_a), 32'd0);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    check("rst_out_b", 32'(out_b), 32'd0);
    check("rst_cnt_b", cnt_b, 32'd0);
    @(negedge clk);
    areset_n = 1'b1;
    step();
    check("rel_out", 32'(out_a), 32'hF);
    check("rel_rise", 32'(rise_a), 32'hF);
    check("rel_cnt_a", 32'(cnt_a), EvCnt ? 32'h55 : 32'h0);
    check("rel_cnt_b", cnt_b, EvCnt ? 32'h01010101 : 32'h0);
    step();
    check("rel_rise_once", 32'(rise_a), 32'h0);

    // Random truth table; DUT b must be the registered in1 & ~in2
    for (int k = 0; k < 200; k++) begin
      pin1 = 4'($urandom);
      pin2 = 4'($urandom);
      in1 = pin1; in2 = pin2;
      step();
      check("tt_out_b", 32'(out_b), 32'(pin1 & ~pin2));
    end

    // Blanking on ch0
    in1 = 4'b0001; in2 = 4'b0000;
    repeat (5) step();
    in2 = 4'b0001; step();
    check("blk_n", 32'(out_a[0]), 32'd0);
    in2 = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("blk_out0", 32'(out_a[0]), (k == 4) ? 32'd1 : 32'd0);
      check("blk_rise0", 32'(rise_a[0]), (k == 4) ? 32'd1 : 32'd0);
    end

    // Retrigger at N+2 restarts the window
    in2 = 4'b0000; repeat (5) step();
    in2 = 4'b0001; step();
    for (int k = 1; k <= 7; k++) begin
      in2 = (k == 2) ? 4'b0001 : 4'b0000;
      step();
      check("rtg_out0", 32'(out_a[0]), (k >= 6) ? 32'd1 : 32'd0);
    end

    // Enable low for 5 edges; blanking must keep running underneath
    in1 = 4'hF; in2 = 4'h0; repeat (5) step();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in2 = (k == 0) ? 4'hF : 4'h0;
      step();
      check("en0_out", 32'(out_a), 32'h0);
      check("en0_rise", 32'(rise_a), 32'h0);
    end
    en = 1'b1; step();
    check("en1_out", 32'(out_a), 32'hF);
    check("en1_rise", 32'(rise_a), 32'hF);
    step();
    check("en1_rise_once", 32'(rise_a), 32'h0);

    // Saturation on ch1 of the 2-bit counters
    in1 = 4'h0; in2 = 4'h0; clr = 1'b1; step();
    clr = 1'b0; step();
    for (int k = 0; k < 5; k++) begin
      in1 = 4'b0010; step();
      check("sat_cnt1", 32'(cnt_a[3:2]), EvCnt ? 32'(sat_exp[k]) : 32'd0);
      in1 = 4'b0000; step();
    end
    in1 = 4'b0010; clr = 1'b1; step();
    check("clr_rise1", 32'(rise_a[1]), 32'd1);
    check("clr_cnt1", 32'(cnt_a[3:2]), 32'd0);
    clr = 1'b0; in1 = 4'h0; step();

    // Reset in the middle of a blanking window
    in1 = 4'hF; in2 = 4'hF; step();
    #2;
    areset_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_out", 32'(out_a), 32'h0);
    @(negedge clk);
    areset_n = 1'b1; in2 = 4'h0;
    step();
    check("mid_rst_pass", 32'(out_a), 32'hF);
    check("mid_rst_rise", 32'(rise_a), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
